wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter placed directly upstream of the ram slave.
- Lets the test master and a second bus master (boot loader or debug port) share the ram over a single Wishbone bus.
- Uses round-robin arbitration. Grant is locked for the whole CYC (including CTI bursts).
- A bus watchdog aborts any cycle the slave never terminates.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, number of cycles a strobed transfer may wait for ACK/ERR/RTY before abort; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m0_CYC, m0_STB, m0_WE  in  1 each  master 0 bus controls
- m0_ADR  in  ADDR_W  master 0 address
- m0_DAT_W  in  DATA_W  master 0 write data
- m0_CTI  in  3  master 0 cycle type
- m0_DAT_R  out  DATA_W  read data to master 0
- m0_ACK, m0_ERR, m0_RTY  out  1 each  terminations to master 0
- m1_*  same set as m0_*  master 1
- s_CYC, s_STB, s_WE  out  1 each  slave bus controls
- s_ADR  out  ADDR_W  slave address
- s_DAT_W  out  DATA_W  write data to slave
- s_CTI  out  3  slave cycle type
- s_DAT_R  in  DATA_W  slave read data
- s_ACK, s_ERR, s_RTY  in  1 each  slave terminations
- gnt  out  2  one-hot current grant (bit0 = m0, bit1 = m1), 00 when idle

Behaviour:
- Clock is clk; reset rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, gnt = 00, last_grant = m1 (so m0 wins the first tie), watchdog count = 0
  - s_CYC = s_STB = s_WE = 0; s_ADR, s_DAT_W = 0; s_CTI = 0
  - all m*_ACK/ERR/RTY = 0
- Reset mid-transfer drops s_CYC/s_STB immediately (asynchronous).
- States: IDLE, GNT0, GNT1, ABORT.
- IDLE:
  - s_CYC = s_STB = 0.
  - If only mX_CYC = 1 at a rising edge, go to GNTX.
  - If both are 1, grant the master that is not last_grant.
  - Arbitration latency is 1 cycle from CYC rise to s_CYC.
- GNTX:
  - s_CYC, s_STB, s_WE, s_ADR, s_DAT_W, s_CTI follow mX_* combinationally.
  - mX_ACK/ERR/RTY = s_ACK/ERR/RTY combinationally. The non-granted master sees 0 on all terminations.
  - s_DAT_R is broadcast to both m*_DAT_R.
  - last_grant = X on entry.
  - Grant is held while mX_CYC = 1, regardless of the other master and of CTI (bursts 010 are not interrupted).
  - mX_CYC = 0 sampled at an edge -> IDLE. The next grant needs 1 further cycle (1 idle bus cycle between owners).
- Non-granted master:
  - Its requests wait with no termination.
  - It must keep CYC asserted; it is not queued otherwise.
- Watchdog (TIMEOUT > 0):
  - Counter increments each cycle in GNTX with s_STB = 1 and no s_ACK/ERR/RTY.
  - Cleared on any termination or s_STB = 0.
  - When the counter reaches TIMEOUT with still no termination:
    - mX_ERR is driven 1 for exactly that one cycle, generated by the arbiter (not the slave).
    - State moves to ABORT.
- ABORT:
  - s_CYC = s_STB = 0; no terminations to either master.
  - Remain until mX_CYC = 0, then IDLE.
- Simultaneous events:
  - Slave termination in the same cycle the counter hits TIMEOUT: the slave termination wins and there is no abort.
  - Slave ERR/RTY passes through unchanged and does not release the grant.

Test Plan:
- Reset, then m0 single write (ADR=0x10, DAT=0xDEADBEEF) -> s_CYC one cycle after m0_CYC, gnt=01, m0_ACK mirrors s_ACK, m1 sees no ACK; ram read-back returns 0xDEADBEEF.
- m0 and m1 raise CYC the same cycle -> m0 granted first; after m0 drops CYC, one idle cycle, then gnt=10; second tie -> m1 loses, m0 granted (round-robin alternation over 4 ties: 01,10,01,10).
- m1 does a 4-beat incrementing burst (CTI 010,010,010,111) while m0 requests mid-burst -> gnt stays 10 for all 4 ACKs; m0 granted only after m1_CYC falls.
- TIMEOUT=8, slave held without ACK -> m0_ERR pulses for exactly 1 cycle at cycle 8 of STB; s_CYC low the next cycle; gnt=00 after m0 drops CYC.
- s_ACK arrives on the exact cycle the counter hits TIMEOUT -> m0_ACK=1, m0_ERR=0, no ABORT.
- rst asserted mid-burst (beat 2) -> s_CYC, s_STB, gnt go to 0 asynchronously before the next clk edge; after release, m0 wins the first tie.

Source files
------------

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter2
//  Description : Two-master / one-slave Wishbone arbiter with round-robin
//                grant locked for the whole CYC and a bus-hang watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_CYC,
    input  logic              m0_STB,
    input  logic              m0_WE,
    input  logic [ADDR_W-1:0] m0_ADR,
    input  logic [DATA_W-1:0] m0_DAT_W,
    input  logic [2:0]        m0_CTI,
    output logic [DATA_W-1:0] m0_DAT_R,
    output logic              m0_ACK,
    output logic              m0_ERR,
    output logic              m0_RTY,

    input  logic              m1_CYC,
    input  logic              m1_STB,
    input  logic              m1_WE,
    input  logic [ADDR_W-1:0] m1_ADR,
    input  logic [DATA_W-1:0] m1_DAT_W,
    input  logic [2:0]        m1_CTI,
    output logic [DATA_W-1:0] m1_DAT_R,
    output logic              m1_ACK,
    output logic              m1_ERR,
    output logic              m1_RTY,

    output logic              s_CYC,
    output logic              s_STB,
    output logic              s_WE,
    output logic [ADDR_W-1:0] s_ADR,
    output logic [DATA_W-1:0] s_DAT_W,
    output logic [2:0]        s_CTI,
    input  logic [DATA_W-1:0] s_DAT_R,
    input  logic              s_ACK,
    input  logic              s_ERR,
    input  logic              s_RTY,

    output logic [1:0]        gnt
);

    // The counter only ever needs to hold TIMEOUT-1: the abort fires on the
    // cycle that would have been the TIMEOUT-th unterminated strobe.
    localparam int               WDT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT0  = 2'd1,
        S_GNT1  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;      // 0: m0 owned the bus last, 1: m1
    logic [WDT_W-1:0]  r_wdt;

    logic              w_sel1;
    logic              w_granted;
    logic              w_cyc;
    logic              w_stb;
    logic              w_we;
    logic [ADDR_W-1:0] w_adr;
    logic [DATA_W-1:0] w_dat;
    logic [2:0]        w_cti;
    logic              w_term;
    logic              w_timeout;
    logic              w_owner_cyc;

    assign w_sel1      = (r_state == S_GNT1);
    assign w_granted   = (r_state == S_GNT0) || (r_state == S_GNT1);
    assign w_cyc       = w_sel1 ? m1_CYC   : m0_CYC;
    assign w_stb       = w_sel1 ? m1_STB   : m0_STB;
    assign w_we        = w_sel1 ? m1_WE    : m0_WE;
    assign w_adr       = w_sel1 ? m1_ADR   : m0_ADR;
    assign w_dat       = w_sel1 ? m1_DAT_W : m0_DAT_W;
    assign w_cti       = w_sel1 ? m1_CTI   : m0_CTI;
    assign w_term      = s_ACK | s_ERR | s_RTY;
    // A real slave termination in the same cycle always beats the abort.
    assign w_timeout   = (TIMEOUT != 0) && w_granted && w_stb && !w_term && (r_wdt == WDT_LAST);
    assign w_owner_cyc = r_last ? m1_CYC : m0_CYC;

    assign m0_DAT_R = s_DAT_R;
    assign m1_DAT_R = s_DAT_R;

    always_comb begin
        w_next  = r_state;
        s_CYC   = 1'b0;
        s_STB   = 1'b0;
        s_WE    = 1'b0;
        s_ADR   = '0;
        s_DAT_W = '0;
        s_CTI   = 3'b000;
        m0_ACK  = 1'b0;
        m0_ERR  = 1'b0;
        m0_RTY  = 1'b0;
        m1_ACK  = 1'b0;
        m1_ERR  = 1'b0;
        m1_RTY  = 1'b0;
        gnt     = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (m0_CYC && (!m1_CYC || r_last)) begin
                    w_next = S_GNT0;
                end else if (m1_CYC) begin
                    w_next = S_GNT1;
                end
            end

            S_GNT0, S_GNT1: begin
                s_CYC   = w_cyc;
                s_STB   = w_stb;
                s_WE    = w_we;
                s_ADR   = w_adr;
                s_DAT_W = w_dat;
                s_CTI   = w_cti;
                gnt     = w_sel1 ? 2'b10 : 2'b01;
                if (w_sel1) begin
                    m1_ACK = s_ACK;
                    m1_ERR = s_ERR | w_timeout;
                    m1_RTY = s_RTY;
                end else begin
                    m0_ACK = s_ACK;
                    m0_ERR = s_ERR | w_timeout;
                    m0_RTY = s_RTY;
                end
                if (!w_cyc) begin
                    w_next = S_IDLE;
                end else if (w_timeout) begin
                    w_next = S_ABORT;
                end
            end

            S_ABORT: begin
                // Bus is released but the owner keeps the lock until it drops CYC.
                gnt = r_last ? 2'b10 : 2'b01;
                if (!w_owner_cyc) begin
                    w_next = S_IDLE;
                end
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_wdt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (w_next == S_GNT0) begin
                    r_last <= 1'b0;
                end else if (w_next == S_GNT1) begin
                    r_last <= 1'b1;
                end
            end
            if ((TIMEOUT != 0) && w_granted && w_stb && !w_term && !w_timeout) begin
                r_wdt <= r_wdt + WDT_ONE;
            end else begin
                r_wdt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter2
//  Description : Scenario bench for wb_arbiter2 with a small RAM slave model
//                and per-master expected-termination queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cyc, stb, we;
    logic [AW-1:0] adr  [2];
    logic [DW-1:0] datw [2];
    logic [2:0]    cti  [2];

    logic [DW-1:0] m0_dat_r, m1_dat_r;
    logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w, s_dat_r;
    logic [2:0]    s_cti;
    logic          s_ack, s_err, s_rty;
    logic [1:0]    gnt;

    wb_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_CYC(cyc[0]), .m0_STB(stb[0]), .m0_WE(we[0]), .m0_ADR(adr[0]),
        .m0_DAT_W(datw[0]), .m0_CTI(cti[0]), .m0_DAT_R(m0_dat_r),
        .m0_ACK(m0_ack), .m0_ERR(m0_err), .m0_RTY(m0_rty),
        .m1_CYC(cyc[1]), .m1_STB(stb[1]), .m1_WE(we[1]), .m1_ADR(adr[1]),
        .m1_DAT_W(datw[1]), .m1_CTI(cti[1]), .m1_DAT_R(m1_dat_r),
        .m1_ACK(m1_ack), .m1_ERR(m1_err), .m1_RTY(m1_rty),
        .s_CYC(s_cyc), .s_STB(s_stb), .s_WE(s_we), .s_ADR(s_adr),
        .s_DAT_W(s_dat_w), .s_CTI(s_cti), .s_DAT_R(s_dat_r),
        .s_ACK(s_ack), .s_ERR(s_err), .s_RTY(s_rty),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    // RAM slave: mode 0 = registered ACK, 1 = never terminates,
    // 2 = combinational ACK on strobe cycle number ack_cycle.
    int            mode;
    int            ack_cycle;
    logic          r_ack;
    logic [7:0]    sc;
    logic [DW-1:0] mem [256];

    assign s_ack = (mode == 2) ? (s_cyc && s_stb && (sc == 8'(ack_cycle - 1))) : r_ack;
    assign s_err = 1'b0;
    assign s_rty = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack <= 1'b0;
            sc    <= 8'd0;
        end else begin
            r_ack <= (mode == 0) && s_cyc && s_stb && !r_ack;
            sc    <= (s_cyc && s_stb && !s_ack) ? sc + 8'd1 : 8'd0;
            if (s_cyc && s_stb && s_we && s_ack) mem[s_adr[7:0]] <= s_dat_w;
            s_dat_r <= mem[s_adr[7:0]];
        end
    end

    typedef struct { logic w; logic [DW-1:0] dat; } exp_t;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e_mon;
    int   tests = 0;
    int   fails = 0;

    always @(negedge clk) begin
        if (!rst && (m0_ack || m1_ack)) begin
            tests++;
            if (m0_ack && m1_ack) begin
                fails++;
                $display("FAIL sb_both_ack m0_ack=%b m1_ack=%b required only one", m0_ack, m1_ack);
            end else if ((m0_ack ? sb0.size() : sb1.size()) == 0) begin
                fails++;
                $display("FAIL sb_unexpected_ack m%0d ack with no transfer expected", m1_ack ? 1 : 0);
            end else begin
                e_mon = m0_ack ? sb0.pop_front() : sb1.pop_front();
                if (!e_mon.w && ((m0_ack ? m0_dat_r : m1_dat_r) !== e_mon.dat)) begin
                    fails++;
                    $display("FAIL sb_read_data m%0d got %h required %h", m1_ack ? 1 : 0,
                             m0_ack ? m0_dat_r : m1_dat_r, e_mon.dat);
                end
            end
        end
    end

    task automatic exp_push(input int m, input logic w, input logic [DW-1:0] d);
        exp_t e;
        e.w = w;
        e.dat = d;
        if (m == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic start(input int m, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] c);
        cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; adr[m] = a; datw[m] = d; cti[m] = c;
    endtask

    task automatic release_m(input int m);
        cyc[m] = 1'b0; stb[m] = 1'b0; we[m] = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int m, input string name);
        int n = 0;
        @(negedge clk);
        while (!(m == 1 ? m1_ack : m0_ack) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++; fails++;
            $display("FAIL %s no ack from m%0d within 40 cycles, required ack", name, m);
        end
    endtask

    task automatic solo(input int m, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string name);
        tick;
        start(m, w, a, d, 3'b000);
        exp_push(m, w, d);
        wait_ack(m, name);
        tests++;
        if ((m == 1 ? m0_ack : m1_ack) !== 1'b0) begin
            fails++; $display("FAIL %s other master saw ack=1 required 0", name);
        end
        tick;
        release_m(m);
    endtask

    task automatic tie_round(input int win);
        int         lose = 1 - win;
        logic [1:0] gw = (win == 1) ? 2'b10 : 2'b01;
        logic [1:0] gl = (win == 1) ? 2'b01 : 2'b10;
        tick;
        start(0, 1'b1, 32'h30 + 32'(win), 32'hA000_0000 + 32'(win), 3'b000);
        start(1, 1'b1, 32'h34 + 32'(win), 32'hB000_0000 + 32'(win), 3'b000);
        exp_push(win, 1'b1, 32'h0);
        exp_push(lose, 1'b1, 32'h0);
        @(negedge clk);
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL tie_latency gnt=%b required 00", gnt); end
        @(negedge clk);
        tests++; if (gnt !== gw) begin fails++; $display("FAIL tie_winner gnt=%b required %b", gnt, gw); end
        wait_ack(win, "tie_winner_ack");
        tick;
        release_m(win);
        @(negedge clk);
        @(negedge clk);
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL tie_idle_gap gnt=%b required 00", gnt); end
        @(negedge clk);
        tests++; if (gnt !== gl) begin fails++; $display("FAIL tie_loser gnt=%b required %b", gnt, gl); end
        wait_ack(lose, "tie_loser_ack");
        tick;
        release_m(lose);
    endtask

    task automatic test_reset;
        adr[0] = 32'h55; datw[0] = 32'h1234_5678; cti[0] = 3'b111;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt gnt=%b required 00", gnt); end
        tests++;
        if ({s_cyc, s_stb, s_we} !== 3'b000 || s_adr !== '0 || s_dat_w !== '0 || s_cti !== 3'b000) begin
            fails++;
            $display("FAIL reset_slave_bus cyc/stb/we=%b%b%b adr=%h dat=%h cti=%b required all 0",
                     s_cyc, s_stb, s_we, s_adr, s_dat_w, s_cti);
        end
        tests++;
        if ({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !== 6'b0) begin
            fails++;
            $display("FAIL reset_terms got %b required 000000", {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty});
        end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_single_write;
        tick;
        start(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b000);
        exp_push(0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        tests++; if (s_cyc !== 1'b0) begin fails++; $display("FAIL arb_latency s_CYC=%b required 0", s_cyc); end
        @(negedge clk);
        tests++;
        if (s_cyc !== 1'b1 || gnt !== 2'b01 || s_adr !== 32'h10 || s_dat_w !== 32'hDEAD_BEEF || s_we !== 1'b1) begin
            fails++;
            $display("FAIL single_grant s_CYC=%b gnt=%b adr=%h dat=%h we=%b required 1 01 10 deadbeef 1",
                     s_cyc, gnt, s_adr, s_dat_w, s_we);
        end
        wait_ack(0, "single_write_ack");
        tests++;
        if (m0_ack !== s_ack || m1_ack !== 1'b0) begin
            fails++; $display("FAIL single_ack_route m0_ack=%b m1_ack=%b required 1 0", m0_ack, m1_ack);
        end
        tick;
        release_m(0);
        solo(0, 1'b0, 32'h10, 32'hDEAD_BEEF, "readback_m0");
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tie_round(0);
        tie_round(0);
        solo(0, 1'b1, 32'h38, 32'h0000_0038, "rr_solo_m0");
        tie_round(1);
    endtask

    task automatic test_burst;
        logic [2:0] c;
        tick;
        start(1, 1'b1, 32'h40, 32'hC000_0000, 3'b010);
        exp_push(1, 1'b1, 32'hC000_0000);
        for (int b = 0; b < 4; b++) begin
            wait_ack(1, "burst_ack");
            c = (b == 3) ? 3'b111 : 3'b010;
            tests++;
            if (gnt !== 2'b10 || m0_ack !== 1'b0 || s_cti !== c) begin
                fails++;
                $display("FAIL burst_hold beat=%0d gnt=%b m0_ack=%b cti=%b required 10 0 %b", b, gnt, m0_ack, s_cti, c);
            end
            tick;
            if (b == 0) begin
                start(0, 1'b1, 32'h50, 32'hCAFE_0050, 3'b000);
                exp_push(0, 1'b1, 32'hCAFE_0050);
            end
            if (b < 3) begin
                adr[1]  = 32'h41 + 32'(b);
                datw[1] = 32'hC000_0001 + 32'(b);
                cti[1]  = (b == 2) ? 3'b111 : 3'b010;
                exp_push(1, 1'b1, datw[1]);
            end else begin
                release_m(1);
            end
        end
        @(negedge clk);
        @(negedge clk);
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL burst_idle_gap gnt=%b required 00", gnt); end
        @(negedge clk);
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL burst_then_m0 gnt=%b required 01", gnt); end
        wait_ack(0, "burst_m0_ack");
        tick;
        release_m(0);
        solo(1, 1'b0, 32'h42, 32'hC000_0002, "readback_m1");
    endtask

    task automatic test_timeout;
        mode = 1;
        tick;
        start(0, 1'b0, 32'h60, 32'h0, 3'b000);
        @(negedge clk);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            tests++;
            if (m0_err !== (k == TO) || m1_err !== 1'b0 || s_cyc !== 1'b1) begin
                fails++;
                $display("FAIL watchdog_err cycle=%0d m0_err=%b m1_err=%b s_CYC=%b required %b 0 1",
                         k, m0_err, m1_err, s_cyc, k == TO);
            end
        end
        @(negedge clk);
        tests++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m0_err !== 1'b0) begin
            fails++;
            $display("FAIL abort_drop s_CYC=%b s_STB=%b m0_err=%b required 0 0 0", s_cyc, s_stb, m0_err);
        end
        tick;
        release_m(0);
        @(negedge clk);
        @(negedge clk);
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL abort_release gnt=%b required 00", gnt); end
        mode = 0;
    endtask

    task automatic test_ack_at_timeout;
        mode = 2;
        ack_cycle = TO;
        tick;
        start(0, 1'b0, 32'h10, 32'h0, 3'b000);
        exp_push(0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            tests++;
            if (m0_ack !== (k == TO) || m0_err !== 1'b0) begin
                fails++;
                $display("FAIL ack_vs_timeout cycle=%0d m0_ack=%b m0_err=%b required %b 0", k, m0_ack, m0_err, k == TO);
            end
        end
        tick;
        stb[0] = 1'b0;
        @(negedge clk);
        tests++; if (s_cyc !== 1'b1) begin fails++; $display("FAIL no_abort s_CYC=%b required 1", s_cyc); end
        tick;
        release_m(0);
        tick;
        mode = 0;
    endtask

    task automatic test_reset_mid_burst;
        tick;
        start(1, 1'b1, 32'h70, 32'hD000_0000, 3'b010);
        exp_push(1, 1'b1, 32'hD000_0000);
        wait_ack(1, "rst_burst_beat1");
        tick;
        adr[1] = 32'h71; datw[1] = 32'hD000_0001;
        @(negedge clk);
        tests++;
        if (s_cyc !== 1'b1 || gnt !== 2'b10) begin
            fails++; $display("FAIL rst_burst_beat2 s_CYC=%b gnt=%b required 1 10", s_cyc, gnt);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0 || gnt !== 2'b00) begin
            fails++; $display("FAIL async_reset s_CYC=%b s_STB=%b gnt=%b required 0 0 00", s_cyc, s_stb, gnt);
        end
        release_m(1);
        tick;
        rst = 1'b0;
        tick;
        start(0, 1'b1, 32'h80, 32'hE000_0000, 3'b000);
        start(1, 1'b1, 32'h81, 32'hE000_0001, 3'b000);
        exp_push(0, 1'b1, 32'hE000_0000);
        exp_push(1, 1'b1, 32'hE000_0001);
        @(negedge clk);
        @(negedge clk);
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL post_reset_tie gnt=%b required 01", gnt); end
        wait_ack(0, "post_reset_m0");
        tick;
        release_m(0);
        wait_ack(1, "post_reset_m1");
        tick;
        release_m(1);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        cyc = 2'b00; stb = 2'b00; we = 2'b00;
        for (int i = 0; i < 2; i++) begin
            adr[i] = '0; datw[i] = '0; cti[i] = 3'b000;
        end
        mode = 0;
        ack_cycle = 0;

        test_reset;
        test_single_write;
        test_round_robin;
        test_burst;
        test_timeout;
        test_ack_at_timeout;
        test_reset_mid_burst;

        tests++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            fails++;
            $display("FAIL sb_drain pending m0=%0d m1=%0d required 0 0", sb0.size(), sb1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
